// File: rtl/npu_post_proc_array.sv
// Multi-channel accumulator post-processor: bias add, round-half-up shift,
// saturation, optional ReLU and optional 2x1 max-pool over consecutive tokens.
module npu_post_proc_array #(
    parameter int CH      = 4,
    parameter int ACC_W   = 20,
    parameter int BIAS_W  = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_en,
    input  logic [CH*ACC_W-1:0]   acc_in,
    input  logic [CH*BIAS_W-1:0]  bias_in,
    input  logic [SHIFT_W-1:0]    bound_level,
    input  logic                  en_relu,
    input  logic                  en_mp,
    input  logic                  mp_clear,
    output logic [CH*OUT_W-1:0]   out,
    output logic                  out_en
);

    localparam int SUM_W  = ACC_W + 1;
    localparam int WIDE_W = ACC_W + 2;
    localparam logic signed [WIDE_W-1:0] SAT_HI = WIDE_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [WIDE_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic {EMPTY, HALF} pool_state_t;

    logic                     s1_valid;
    logic signed [SUM_W-1:0]  s1_sum   [CH];
    logic [SHIFT_W-1:0]       s1_bl;
    logic                     s1_relu;
    logic signed [SUM_W-1:0]  sum_next [CH];

    logic [WIDE_W-1:0]        half_lsb;
    logic signed [WIDE_W-1:0] shifted  [CH];
    logic signed [OUT_W-1:0]  res_next [CH];

    logic                     s2_valid;
    logic signed [OUT_W-1:0]  s2_res   [CH];

    pool_state_t              state;
    pool_state_t              state_next;
    logic signed [OUT_W-1:0]  hold     [CH];
    logic                     hold_load;
    logic [CH*OUT_W-1:0]      s2_flat;
    logic [CH*OUT_W-1:0]      max_flat;
    logic [CH*OUT_W-1:0]      out_next;
    logic                     out_en_next;

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            sum_next[c] = $signed({acc_in[c*ACC_W+ACC_W-1], acc_in[c*ACC_W +: ACC_W]})
                        + $signed({{(SUM_W-BIAS_W){bias_in[c*BIAS_W+BIAS_W-1]}},
                                   bias_in[c*BIAS_W +: BIAS_W]});
        end
    end

    // Shift amount and ReLU mode are latched with the token so later config changes do not affect it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_bl    <= '0;
            s1_relu  <= 1'b0;
            for (int c = 0; c < CH; c++) s1_sum[c] <= '0;
        end else begin
            s1_valid <= in_en;
            if (in_en) begin
                s1_bl   <= bound_level;
                s1_relu <= en_relu;
                for (int c = 0; c < CH; c++) s1_sum[c] <= sum_next[c];
            end
        end
    end

    // Rounding constant is half an output LSB, which collapses to zero when no shift is applied.
    always_comb begin
        half_lsb = ({{(WIDE_W-1){1'b0}}, 1'b1} << s1_bl) >> 1;
        for (int c = 0; c < CH; c++) begin
            shifted[c] = ($signed({s1_sum[c][SUM_W-1], s1_sum[c]}) + $signed(half_lsb)) >>> s1_bl;
            if (shifted[c] > SAT_HI)
                res_next[c] = {1'b0, {(OUT_W-1){1'b1}}};
            else if (shifted[c] < SAT_LO)
                res_next[c] = {1'b1, {(OUT_W-1){1'b0}}};
            else
                res_next[c] = shifted[c][OUT_W-1:0];
            if (s1_relu && res_next[c][OUT_W-1])
                res_next[c] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            for (int c = 0; c < CH; c++) s2_res[c] <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int c = 0; c < CH; c++) s2_res[c] <= res_next[c];
            end
        end
    end

    // A clear arriving with a token empties the pool first, so that token opens a fresh pair.
    always_comb begin
        state_next  = state;
        out_next    = out;
        out_en_next = 1'b0;
        hold_load   = 1'b0;
        s2_flat     = '0;
        max_flat    = '0;
        for (int c = 0; c < CH; c++) begin
            s2_flat[c*OUT_W +: OUT_W]  = s2_res[c];
            max_flat[c*OUT_W +: OUT_W] = (hold[c] > s2_res[c]) ? hold[c] : s2_res[c];
        end
        if (mp_clear)
            state_next = EMPTY;
        if (s2_valid) begin
            if (!en_mp) begin
                out_next    = s2_flat;
                out_en_next = 1'b1;
                state_next  = EMPTY;
            end else if (mp_clear || state == EMPTY) begin
                hold_load  = 1'b1;
                state_next = HALF;
            end else begin
                out_next    = max_flat;
                out_en_next = 1'b1;
                state_next  = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= EMPTY;
            out    <= '0;
            out_en <= 1'b0;
            for (int c = 0; c < CH; c++) hold[c] <= '0;
        end else begin
            state  <= state_next;
            out    <= out_next;
            out_en <= out_en_next;
            if (hold_load) begin
                for (int c = 0; c < CH; c++) hold[c] <= s2_res[c];
            end
        end
    end

endmodule
